// File: rtl/prog_mode_ctrl_pkg.sv
// Shared encodings for the program-mode controller.
// The state codes double as the mode_o values seen by software.
package prog_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LOAD    = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam int          DMEM_SEL_BIT   = 14;
  localparam logic [15:0] LOAD_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/prog_mode_ctrl_debounce.sv
// Synchronises and debounces the raw start_pg button; emits a one-cycle
// press pulse when the accepted level goes 0->1.
module button_debounce #(
  parameter int DB_CYCLES = 200000
) (
  input  logic clock,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      // A new level is accepted only after DB_CYCLES consecutive differing samples.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/prog_mode_ctrl.sv
// Hands ROM/RAM ownership between CPU and UART loader and sequences their resets.
// Optional load-idle abort is enabled by defining PROG_LOAD_TIMEOUT_EN.
import prog_ctrl_pkg::*;

module prog_mode_ctrl #(
  parameter int DB_CYCLES      = 200000,
  parameter int RELEASE_CYCLES = 16
`ifdef PROG_LOAD_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
`endif
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        upg_done_i,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        imem_wen_o,
  output logic        dmem_wen_o,
  output logic [1:0]  mode_o,
  output logic [15:0] load_count_o,
  output logic        abort_o
);

  localparam int            RW       = $clog2(RELEASE_CYCLES + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] rel_cnt;
  logic          done_q;
  logic          press;
  logic          in_load;
  logic          done_rise;
  logic          timeout;
  logic          load_entry;
  logic          unused_adr;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clock (clock),
    .rst   (rst),
    .raw   (start_pg),
    .press (press)
  );

  assign in_load    = (state == ST_LOAD);
  assign done_rise  = upg_done_i & ~done_q;
  assign imem_wen_o = in_load & upg_wen_i & ~upg_adr_i[DMEM_SEL_BIT];
  assign dmem_wen_o = in_load & upg_wen_i &  upg_adr_i[DMEM_SEL_BIT];
  assign unused_adr = ^upg_adr_i[DMEM_SEL_BIT-1:0];

`ifdef PROG_LOAD_TIMEOUT_EN
  logic [23:0] idle_cnt;
  logic        abort_q;

  // A finishing loader wins over a coincident idle expiry.
  assign timeout = in_load & ~upg_wen_i & ~done_rise &
                   (idle_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      if (!in_load || upg_wen_i) idle_cnt <= '0;
      else                       idle_cnt <= idle_cnt + 24'd1;
      if (load_entry)   abort_q <= 1'b0;
      else if (timeout) abort_q <= 1'b1;
    end
  end

  assign abort_o = abort_q;
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    load_entry = 1'b0;
    case (state)
      ST_RUN: begin
        if (press) begin
          state_nx   = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (done_rise || timeout) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rel_cnt == REL_LAST) state_nx = ST_RUN;
      end
      default: state_nx = ST_RELEASE;
    endcase
  end

  // Reset outputs are decoded from next-state so they move on the same edge as state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= ST_RELEASE;
      rel_cnt      <= '0;
      done_q       <= 1'b0;
      load_count_o <= '0;
      upg_rst_o    <= 1'b1;
      cpu_rst_o    <= 1'b1;
      mode_o       <= ST_RELEASE;
    end else begin
      state  <= state_nx;
      done_q <= upg_done_i;
      if (state == ST_RELEASE && state_nx == ST_RELEASE) rel_cnt <= rel_cnt + RW'(1);
      else                                               rel_cnt <= '0;
      if (load_entry)
        load_count_o <= '0;
      else if (in_load && upg_wen_i && load_count_o != LOAD_COUNT_MAX)
        load_count_o <= load_count_o + 16'd1;
      upg_rst_o <= (state_nx != ST_LOAD);
      cpu_rst_o <= (state_nx != ST_RUN);
      mode_o    <= state_nx;
    end
  end

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// Self-checking bench for prog_mode_ctrl with small debounce/release constants.
// Define PROG_LOAD_TIMEOUT_EN to also exercise the load-idle abort.
`timescale 1ns/1ps
module tb_prog_mode_ctrl;

  localparam int DB  = 4;
  localparam int REL = 3;
`ifdef PROG_LOAD_TIMEOUT_EN
  localparam logic [23:0] TO = 24'd10;
`endif
  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_REL  = 2'b10;

  logic        clock;
  logic        rst;
  logic        start_pg;
  logic        upg_done_i;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic        imem_wen_o;
  logic        dmem_wen_o;
  logic [1:0]  mode_o;
  logic [15:0] load_count_o;
  logic        abort_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  int          exp_count = 0;
  logic        exp_abort = 1'b0;

  prog_mode_ctrl #(
    .DB_CYCLES      (DB),
    .RELEASE_CYCLES (REL)
`ifdef PROG_LOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .start_pg     (start_pg),
    .upg_done_i   (upg_done_i),
    .upg_wen_i    (upg_wen_i),
    .upg_adr_i    (upg_adr_i),
    .upg_rst_o    (upg_rst_o),
    .cpu_rst_o    (cpu_rst_o),
    .imem_wen_o   (imem_wen_o),
    .dmem_wen_o   (dmem_wen_o),
    .mode_o       (mode_o),
    .load_count_o (load_count_o),
    .abort_o      (abort_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  // drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (mode_o === m) begin
        n = i;
        break;
      end
    end
  endtask

  // Debounced press: 2 sync stages + DB stable samples + 1 edge from pulse to state.
  task automatic press(input int hold, output int n);
    repeat (DB + 4) tick();
    start_pg = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == hold) start_pg = 1'b0;
      if (mode_o === M_LOAD) begin
        n = i;
        break;
      end
    end
    start_pg  = 1'b0;
    exp_count = 0;
    exp_abort = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; start_pg = 1'b0; upg_done_i = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks += 5;
    if (mode_o !== M_REL) begin n_fail++; $display("FAIL reset_mode: got %b expected %b", mode_o, M_REL); end
    if (upg_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_upg_rst: got %b expected 1", upg_rst_o); end
    if (cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst_o); end
    if (load_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", load_count_o); end
    if (abort_o !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", abort_o); end
    rst = 1'b0;
    wait_mode(M_RUN, 50, n);
    n_checks += 3;
    if (n !== REL) begin n_fail++; $display("FAIL reset_release_len: got %0d expected %0d", n, REL); end
    if (cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL run_cpu_rst: got %b expected 0", cpu_rst_o); end
    if (upg_rst_o !== 1'b1) begin n_fail++; $display("FAIL run_upg_rst: got %b expected 1", upg_rst_o); end
  endtask

  task automatic test_glitch();
    int glen, bad;
    glen = $urandom_range(DB - 2, 1);
    repeat (DB + 4) tick();
    start_pg = 1'b1;
    repeat (glen) tick();
    start_pg = 1'b0;
    bad = 0;
    repeat (DB + 10) begin
      tick();
      if (mode_o !== M_RUN || upg_rst_o !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL glitch_ignored: got %0d non-RUN cycles expected 0", bad); end
  endtask

  task automatic test_press_entry();
    int n;
    press($urandom_range(DB + 2, DB), n);
    n_checks += 5;
    if (n !== DB + 3) begin n_fail++; $display("FAIL press_latency: got %0d expected %0d", n, DB + 3); end
    if (upg_rst_o !== 1'b0) begin n_fail++; $display("FAIL load_upg_rst: got %b expected 0", upg_rst_o); end
    if (cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL load_cpu_rst: got %b expected 1", cpu_rst_o); end
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL load_count_clear: got %0d expected %0d", load_count_o, exp_count); end
    if (abort_o !== exp_abort) begin n_fail++; $display("FAIL load_abort: got %b expected %b", abort_o, exp_abort); end
  endtask

  // Writes with random gaps while a button press is held (must be ignored in LOAD).
  task automatic test_writes();
    logic [14:0] adrs[$];
    logic [1:0]  exp, got;
    int          k, extra, gap;
    adrs = '{15'h0001, 15'h0002, 15'h4000, 15'h4001, 15'h4002};
    extra = $urandom_range(12, 8);
    for (int i = 0; i < extra; i++) adrs.push_back(15'($urandom));
    foreach (adrs[i]) exp_q.push_back(adrs[i][14] ? 2'b10 : 2'b01);
    k = 0;
    start_pg = 1'b1;
    foreach (adrs[i]) begin
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        upg_wen_i = 1'b0; upg_adr_i = 15'($urandom);
        #1;
        n_checks++;
        if ({dmem_wen_o, imem_wen_o} !== 2'b00) begin
          n_fail++; $display("FAIL idle_enables: got %b expected 00", {dmem_wen_o, imem_wen_o});
        end
        tick(); k++;
        if (k == DB + 2) start_pg = 1'b0;
      end
      upg_wen_i = 1'b1; upg_adr_i = adrs[i];
      #1;
      exp = exp_q.pop_front();
      got = {dmem_wen_o, imem_wen_o};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL write_enables adr=%h: got %b expected %b", adrs[i], got, exp); end
      tick(); k++;
      exp_count = sat_inc(exp_count);
      if (k == DB + 2) start_pg = 1'b0;
    end
    upg_wen_i = 1'b0; start_pg = 1'b0;
    n_checks += 2;
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL write_count: got %0d expected %0d", load_count_o, exp_count); end
    if (mode_o !== M_LOAD) begin n_fail++; $display("FAIL press_in_load: got %b expected %b", mode_o, M_LOAD); end
  endtask

  // Done edge together with a final write: write counts, then RELEASE -> RUN.
  task automatic test_done_with_write();
    int         n;
    logic [1:0] exp;
    upg_done_i = 1'b1; upg_wen_i = 1'b1; upg_adr_i = 15'($urandom);
    exp = upg_adr_i[14] ? 2'b10 : 2'b01;
    #1;
    n_checks++;
    if ({dmem_wen_o, imem_wen_o} !== exp) begin n_fail++; $display("FAIL done_write_en: got %b expected %b", {dmem_wen_o, imem_wen_o}, exp); end
    tick();
    exp_count = sat_inc(exp_count);
    upg_done_i = 1'b0; upg_wen_i = 1'b0;
    n_checks += 3;
    if (mode_o !== M_REL) begin n_fail++; $display("FAIL done_to_release: got %b expected %b", mode_o, M_REL); end
    if (upg_rst_o !== 1'b1) begin n_fail++; $display("FAIL release_upg_rst: got %b expected 1", upg_rst_o); end
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL done_count: got %0d expected %0d", load_count_o, exp_count); end
    wait_mode(M_RUN, 50, n);
    n_checks += 2;
    if (n !== REL) begin n_fail++; $display("FAIL release_len: got %0d expected %0d", n, REL); end
    if (cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL release_cpu_rst: got %b expected 0", cpu_rst_o); end
    upg_wen_i = 1'b1; upg_adr_i = 15'($urandom);
    #1;
    n_checks++;
    if ({dmem_wen_o, imem_wen_o} !== 2'b00) begin n_fail++; $display("FAIL run_enables: got %b expected 00", {dmem_wen_o, imem_wen_o}); end
    tick();
    upg_wen_i = 1'b0;
    n_checks += 2;
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL run_count_hold: got %0d expected %0d", load_count_o, exp_count); end
    if (abort_o !== exp_abort) begin n_fail++; $display("FAIL run_abort: got %b expected %b", abort_o, exp_abort); end
  endtask

  // A done level already high when LOAD is entered must not end the session.
  task automatic test_done_level();
    int n;
    upg_done_i = 1'b1;
    press(DB, n);
    n_checks++;
    if (n !== DB + 3) begin n_fail++; $display("FAIL level_press_latency: got %0d expected %0d", n, DB + 3); end
    repeat (2) tick();
    upg_wen_i = 1'b1; upg_adr_i = 15'($urandom);
    tick();
    exp_count = sat_inc(exp_count);
    upg_wen_i = 1'b0;
    n_checks += 2;
    if (mode_o !== M_LOAD) begin n_fail++; $display("FAIL done_level_ignored: got %b expected %b", mode_o, M_LOAD); end
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL level_count: got %0d expected %0d", load_count_o, exp_count); end
    upg_done_i = 1'b0;
    tick();
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    n_checks++;
    if (mode_o !== M_REL) begin n_fail++; $display("FAIL done_rise_exit: got %b expected %b", mode_o, M_REL); end
    wait_mode(M_RUN, 50, n);
  endtask

  task automatic test_rst_mid_load();
    int n;
    press(DB + 1, n);
    n_checks++;
    if (mode_o !== M_LOAD) begin n_fail++; $display("FAIL rst_pre_load: got %b expected %b", mode_o, M_LOAD); end
    #3;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (upg_rst_o !== 1'b1) begin n_fail++; $display("FAIL rst_async_upg: got %b expected 1", upg_rst_o); end
    if (cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL rst_async_cpu: got %b expected 1", cpu_rst_o); end
    if (mode_o !== M_REL) begin n_fail++; $display("FAIL rst_async_mode: got %b expected %b", mode_o, M_REL); end
    if (load_count_o !== 16'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d expected 0", load_count_o); end
    #2;
    rst = 1'b0;
    exp_count = 0;
    wait_mode(M_RUN, 50, n);
    n_checks++;
    if (n !== REL) begin n_fail++; $display("FAIL rst_release_len: got %0d expected %0d", n, REL); end
  endtask

  task automatic test_saturation();
    int n;
    press(DB, n);
    upg_wen_i = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      upg_adr_i = 15'($urandom);
      tick();
      exp_count = sat_inc(exp_count);
    end
    n_checks++;
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL sat_reach: got %0h expected %0h", load_count_o, exp_count); end
    tick();
    exp_count = sat_inc(exp_count);
    upg_wen_i = 1'b0;
    n_checks++;
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL sat_hold: got %0h expected %0h", load_count_o, exp_count); end
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    wait_mode(M_RUN, 50, n);
    n_checks++;
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL sat_run_hold: got %0h expected %0h", load_count_o, exp_count); end
  endtask

`ifdef PROG_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    press(DB, n);
    wait_mode(M_REL, 40, n);
    exp_abort = 1'b1;
    n_checks += 2;
    if (n !== int'(TO)) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", n, TO); end
    if (abort_o !== exp_abort) begin n_fail++; $display("FAIL timeout_abort: got %b expected %b", abort_o, exp_abort); end
    wait_mode(M_RUN, 50, n);
    n_checks++;
    if (abort_o !== exp_abort) begin n_fail++; $display("FAIL abort_hold_run: got %b expected %b", abort_o, exp_abort); end
    press(DB, n);
    n_checks += 2;
    if (abort_o !== exp_abort) begin n_fail++; $display("FAIL abort_clear: got %b expected %b", abort_o, exp_abort); end
    if (load_count_o !== 16'(exp_count)) begin n_fail++; $display("FAIL timeout_count_clear: got %0d expected %0d", load_count_o, exp_count); end
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    wait_mode(M_RUN, 50, n);
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_press_entry();
    test_writes();
    test_done_with_write();
    test_done_level();
    test_rst_mid_load();
    test_saturation();
`ifdef PROG_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
